elevador_solicitudes: RTL

Upstream request stage for the 3-floor elevator controller. Synchronizes and debounces the call buttons p1..p3. Synchronizes the floor sensors f1..f3. Latches pending calls per floor and clears each call when the car stops at that floor. Presents one registered destination floor to the controller, chosen by direction-aware priority.

---
 rtl/elevador_pkg.sv | 30 +++
 rtl/elevador_solicitudes_if.sv | 22 ++
 rtl/elevador_antirrebote.sv | 33 +++
 rtl/elevador_solicitudes.sv | 67 ++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// elevador_pkg: shared floor encoding, direction type and destination
// priority function for the elevator request stage.
//   elige_destino(pend, piso, dir) -> next target floor (0 = none)
package elevador_pkg;
  localparam int N_PISOS = 3;
  typedef logic [1:0] piso_t;
  localparam piso_t PISO_NONE = 2'd0;
  localparam piso_t PISO_1 = 2'd1;
  localparam piso_t PISO_2 = 2'd2;
  localparam piso_t PISO_3 = 2'd3;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
  // Floors above the car are scanned top-down so the last hit is the lowest,
  // floors below bottom-up so the last hit is the highest. The car's own floor
  // is only a fallback after both directions come up empty.
  function automatic piso_t elige_destino(input logic [N_PISOS-1:0] pend, input piso_t piso, input dir_t dir);
    logic [N_PISOS:0] pv;
    piso_t arriba, abajo, igual;
    pv = {pend, 1'b0};
    arriba = PISO_NONE;
    abajo = PISO_NONE;
    for (int i = N_PISOS; i >= 1; i--)
      if (pv[i] && piso_t'(i) > piso) arriba = piso_t'(i);
    for (int i = 1; i <= N_PISOS; i++)
      if (pv[i] && piso_t'(i) < piso) abajo = piso_t'(i);
    igual = pv[piso] ? piso : PISO_NONE;
    if (dir == DIR_UP)
      return (arriba != PISO_NONE) ? arriba : (abajo != PISO_NONE) ? abajo : igual;
    return (abajo != PISO_NONE) ? abajo : (arriba != PISO_NONE) ? arriba : igual;
  endfunction
endpackage

// File: rtl/elevador_solicitudes_if.sv
// elevador_solicitudes_if: button/sensor/motor inputs and request outputs.
//   slave  : request stage (buttons, sensors, motor in; pend/dest/piso out)
//   master : environment/controller side
interface elevador_solicitudes_if;
  import elevador_pkg::*;
  logic p1, p2, p3;
  logic f1, f2, f3;
  logic mup, mdw;
  logic [N_PISOS-1:0] pend;
  piso_t dest;
  logic dest_valid;
  piso_t piso_act;
  logic sensor_err;
  modport slave (
    input p1, p2, p3, f1, f2, f3, mup, mdw,
    output pend, dest, dest_valid, piso_act, sensor_err
  );
  modport master (
    output p1, p2, p3, f1, f2, f3, mup, mdw,
    input pend, dest, dest_valid, piso_act, sensor_err
  );
endinterface

// File: rtl/elevador_antirrebote.sv
// elevador_antirrebote: 2-flop synchronizer, saturating debounce counter and
// one-cycle press pulse for one call button.
//   clk, reset : clock, synchronous active-high reset
//   raw_i      : raw asynchronous button
//   press_o    : registered one-cycle pulse when a press is accepted
module elevador_antirrebote #(
  parameter int DEB_CYCLES = 2,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic press_o
);
  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEB_CYCLES);
  logic [1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic press_q;
  always_comb cnt_d = !sync_q[1] ? '0 : (cnt_q == DEB) ? cnt_q : cnt_q + CNT_W'(1);
  // Pulse only on the transition into saturation, so a held button fires once.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q <= cnt_d;
      press_q <= (cnt_d == DEB) && (cnt_q != DEB);
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/elevador_solicitudes.sv
// elevador_solicitudes: request stage of the 3-floor elevator. Debounces call
// buttons, tracks the car floor from sensors, latches pending calls and
// presents a registered, direction-aware destination.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of elevador_solicitudes_if
module elevador_solicitudes
  import elevador_pkg::*;
#(
  parameter int DEB_CYCLES = 2,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  elevador_solicitudes_if.slave bus
);
  logic [N_PISOS-1:0] p_raw, f_raw, press, fm_q, fs_q, pend_q, pend_d, clr;
  logic [N_PISOS:0] pv;
  piso_t dest_q, dest_d, piso_q, piso_d;
  dir_t dir_q, dir_d;
  logic err_q, multi, stopped;
  assign p_raw = {bus.p3, bus.p2, bus.p1};
  assign f_raw = {bus.f3, bus.f2, bus.f1};
  for (genvar i = 0; i < N_PISOS; i++) begin : g_boton
    elevador_antirrebote #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clk(clk),
      .reset(reset),
      .raw_i(p_raw[i]),
      .press_o(press[i])
    );
  end
  // A call is only dropped on a clean, stopped reading; clear beats a
  // same-cycle press so calling the floor the car is parked at does nothing.
  always_comb begin
    stopped = !bus.mup && !bus.mdw;
    multi = (fs_q[0] & fs_q[1]) | (fs_q[0] & fs_q[2]) | (fs_q[1] & fs_q[2]);
    clr = fs_q & {N_PISOS{stopped && !multi}};
    pend_d = (pend_q | press) & ~clr;
    piso_d = (fs_q == '0 || multi) ? piso_q : fs_q[0] ? PISO_1 : fs_q[1] ? PISO_2 : PISO_3;
    dir_d = (bus.mup && !bus.mdw) ? DIR_UP : (bus.mdw && !bus.mup) ? DIR_DOWN : dir_q;
    pv = {pend_q, 1'b0};
    dest_d = (dest_q != PISO_NONE && pv[dest_q]) ? dest_q : elige_destino(pend_q, piso_q, dir_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fm_q <= '0;
      fs_q <= '0;
      pend_q <= '0;
      dest_q <= PISO_NONE;
      piso_q <= PISO_NONE;
      dir_q <= DIR_UP;
      err_q <= 1'b0;
    end else begin
      fm_q <= f_raw;
      fs_q <= fm_q;
      pend_q <= pend_d;
      dest_q <= dest_d;
      piso_q <= piso_d;
      dir_q <= dir_d;
      err_q <= multi;
    end
  end
  assign bus.pend = pend_q;
  assign bus.dest = dest_q;
  assign bus.dest_valid = dest_q != PISO_NONE;
  assign bus.piso_act = piso_q;
  assign bus.sensor_err = err_q;
endmodule
